bldc_driver: RTL and testbench

Six-step, hall-commutated BLDC gate driver with PWM on the high side. It adds a duty-cycle soft-start ramp, dead time at every commutation, and hall-sensor connection and fault detection. The block sits between the motor controller (which supplies enable and duty command) and the three-phase half-bridge gate pins. The motor wrapper ANDs `connected` with `~fault` to form its own connected status.

---
 rtl/bldc_driver.sv | 170 +++++++++++++++++
 tb/tb_bldc_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_driver.sv
// bldc_driver: six-step hall-commutated BLDC gate driver.
// High side is PWM-gated, low side is held for the whole step. Adds a
// soft-start duty ramp, dead time on every commutation, and hall
// connection / sequence-fault detection. All outputs are registered.
module bldc_driver #(
    parameter int PHASE_DRIVER_MAX_COUNTER = 'h1FF,
    parameter int MAX_DUTY_CYCLE           = 'h1FF,
    parameter int MIN_DUTY_CYCLE           = 0,
    parameter int DUTY_CYCLE_STEP_RES      = 1,
    parameter int DEAD_TIME                = 3,
    localparam int DUTY_CYCLE_WIDTH        = $clog2(MAX_DUTY_CYCLE + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [2:0]                  hall,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic [2:0]                  phaseH,
    output logic [2:0]                  phaseL,
    output logic                        connected,
    output logic                        fault
);
    localparam int CNT_W = $clog2(PHASE_DRIVER_MAX_COUNTER + 1);
    localparam int DT_W  = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam int DW    = DUTY_CYCLE_WIDTH;

    // Position of a hall code in the forward sequence; 7 marks 000/111.
    function automatic logic [2:0] seq_idx(input logic [2:0] code);
        case (code)
            3'b001:  seq_idx = 3'd0;
            3'b011:  seq_idx = 3'd1;
            3'b010:  seq_idx = 3'd2;
            3'b110:  seq_idx = 3'd3;
            3'b100:  seq_idx = 3'd4;
            3'b101:  seq_idx = 3'd5;
            default: seq_idx = 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        next_idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    logic [2:0]       hall_s1_q, hall_s1_d;
    logic [2:0]       hs_q, hs_d;
    logic [2:0]       hs_prev_q, hs_prev_d;
    logic             connected_q, connected_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    duty_q, duty_d;
    logic [DT_W-1:0]  dead_q, dead_d;
    logic [2:0]       phase_h_q, phase_h_d;
    logic [2:0]       phase_l_q, phase_l_d;

    logic [2:0] idx_new, idx_old;
    logic       hs_valid, prev_valid, adjacent, hs_change, blocked, wrap, pwm_on;
    logic [2:0] h_sel, l_sel;
    int         cmd_i, target_i, ramp_i;

    // Next-state logic: sync chain, status, PWM/duty ramp, dead time, gates.
    always_comb begin
        hall_s1_d = hall;
        hs_d      = hall_s1_q;
        hs_prev_d = hs_q;

        idx_new    = seq_idx(hs_q);
        idx_old    = seq_idx(hs_prev_q);
        hs_valid   = (idx_new != 3'd7);
        prev_valid = (idx_old != 3'd7);
        adjacent   = (idx_new == next_idx(idx_old)) || (idx_old == next_idx(idx_new));
        hs_change  = hs_valid && (hs_q != hs_prev_q);

        // 111 is the floating pull-up pattern; 000 is never a legal code.
        connected_d = (hs_q != 3'b111);
        fault_d     = fault_q || (hs_q == 3'b000) || (hs_change && prev_valid && !adjacent);

        blocked = !en || !connected_q || fault_q;

        wrap  = (cnt_q == CNT_W'(PHASE_DRIVER_MAX_COUNTER));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;

        // Zero command means off; anything else is clamped into range.
        cmd_i = int'(duty_cycle);
        if (cmd_i == 0) begin
            target_i = 0;
        end else if (cmd_i < MIN_DUTY_CYCLE) begin
            target_i = MIN_DUTY_CYCLE;
        end else if (cmd_i > MAX_DUTY_CYCLE) begin
            target_i = MAX_DUTY_CYCLE;
        end else begin
            target_i = cmd_i;
        end

        // Ramp up one step per period, drop to a lower target at once.
        ramp_i = int'(duty_q) + DUTY_CYCLE_STEP_RES;
        duty_d = duty_q;
        if (blocked) begin
            duty_d = DW'(MIN_DUTY_CYCLE);
        end else if (wrap) begin
            if (int'(duty_q) < target_i) begin
                duty_d = (ramp_i > target_i) ? DW'(target_i) : DW'(ramp_i);
            end else begin
                duty_d = DW'(target_i);
            end
        end

        // A new valid code (re)starts the all-off window.
        if (hs_change) begin
            dead_d = DT_W'(DEAD_TIME);
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end else begin
            dead_d = dead_q;
        end

        // Pattern follows hs_prev_q so the old step holds until the
        // dead-time counter has actually been loaded.
        case (hs_prev_q)
            3'b001:  begin h_sel = 3'b001; l_sel = 3'b010; end
            3'b011:  begin h_sel = 3'b001; l_sel = 3'b100; end
            3'b010:  begin h_sel = 3'b010; l_sel = 3'b100; end
            3'b110:  begin h_sel = 3'b010; l_sel = 3'b001; end
            3'b100:  begin h_sel = 3'b100; l_sel = 3'b001; end
            3'b101:  begin h_sel = 3'b100; l_sel = 3'b010; end
            default: begin h_sel = 3'b000; l_sel = 3'b000; end
        endcase

        pwm_on    = int'(cnt_q) < int'(duty_q);
        phase_h_d = 3'b000;
        phase_l_d = 3'b000;
        if (!blocked && (dead_q == '0)) begin
            phase_h_d = pwm_on ? h_sel : 3'b000;
            phase_l_d = l_sel;
        end
    end

    // State registers; sync chain resets to the disconnected code so the
    // release from reset never looks like a 000 fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            hall_s1_q   <= 3'b111;
            hs_q        <= 3'b111;
            hs_prev_q   <= 3'b111;
            connected_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            duty_q      <= '0;
            dead_q      <= '0;
            phase_h_q   <= 3'b000;
            phase_l_q   <= 3'b000;
        end else begin
            hall_s1_q   <= hall_s1_d;
            hs_q        <= hs_d;
            hs_prev_q   <= hs_prev_d;
            connected_q <= connected_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            dead_q      <= dead_d;
            phase_h_q   <= phase_h_d;
            phase_l_q   <= phase_l_d;
        end
    end

    assign phaseH    = phase_h_q;
    assign phaseL    = phase_l_q;
    assign connected = connected_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_bldc_driver.sv
// tb_bldc_driver: self-checking bench for bldc_driver with default parameters.
module tb_bldc_driver;
    localparam int DW     = 9;
    localparam int PERIOD = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    hall;
    logic [DW-1:0] duty_cycle;
    logic [2:0]    phaseH;
    logic [2:0]    phaseL;
    logic          connected;
    logic          fault;

    bldc_driver dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .hall       (hall),
        .duty_cycle (duty_cycle),
        .phaseH     (phaseH),
        .phaseL     (phaseL),
        .connected  (connected),
        .fault      (fault)
    );

    // Clock and reset-relative cycle count (equals the PWM counter value).
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int inv_viol = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Shoot-through and one-hot gate invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (((phaseH & phaseL) != 3'b000) || ($countones(phaseH) > 1) || ($countones(phaseL) > 1))
            inv_viol <= inv_viol + 1;
    end

    typedef struct {
        logic [2:0] hall;
        logic [2:0] exp_h;
        logic [2:0] exp_l;
    } comm_vec_t;
    comm_vec_t comm_tbl[6];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (((cyc % PERIOD) != p) && (n < 2 * PERIOD)) begin
            tick();
            n++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_val(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: actual %0d, no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: actual %0d, expected %0d", name, act, e);
            end
        end
    endtask

    // Measure the next n high-side pulse widths; a missing pulse reads 65535.
    task automatic measure_runs(input int n, input int budget);
        int len, got, c;
        len = 0; got = 0; c = 0;
        while ((got < n) && (c < budget)) begin
            tick();
            c++;
            if (phaseH != 3'b000) begin
                len++;
            end else if (len != 0) begin
                check("ramp_run", 16'(len));
                got++;
                len = 0;
            end
        end
        while (got < n) begin
            check("ramp_run_timeout", 16'hFFFF);
            got++;
        end
    endtask

    // Count cycles over a window where any gate output is on.
    task automatic count_on(input int n, output int on_cnt);
        on_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if ((phaseH != 3'b000) || (phaseL != 3'b000)) on_cnt++;
        end
    endtask

    initial begin
        int on_cnt, hcnt, lbad;
        int first_zero, zero_cnt, hi_cnt, step_viol;
        logic [2:0] last_l, prev_l;

        comm_tbl[0] = '{hall: 3'b011, exp_h: 3'b001, exp_l: 3'b100};
        comm_tbl[1] = '{hall: 3'b010, exp_h: 3'b010, exp_l: 3'b100};
        comm_tbl[2] = '{hall: 3'b110, exp_h: 3'b010, exp_l: 3'b001};
        comm_tbl[3] = '{hall: 3'b100, exp_h: 3'b100, exp_l: 3'b001};
        comm_tbl[4] = '{hall: 3'b101, exp_h: 3'b100, exp_l: 3'b010};
        comm_tbl[5] = '{hall: 3'b001, exp_h: 3'b001, exp_l: 3'b010};

        // 1. Reset: everything low, connected low while reset held.
        reset = 1'b1; en = 1'b1; hall = 3'b001; duty_cycle = 9'h100;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_val(16'h0000);
            check("reset_out", {8'd0, phaseH, phaseL, connected, fault});
        end

        // 2. Soft-start: pulse widths 1..10 over ten periods, low side B.
        duty_cycle = 9'h1FF;
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) expect_val(16'(k));
        measure_runs(10, 12 * PERIOD);
        expect_val(16'b010);
        check("soft_low", {13'd0, phaseL});

        // 3. Commutation through the forward sequence with dead time.
        for (int r = 0; r < 6; r++) begin
            first_zero = 0; zero_cnt = 0; hi_cnt = 0; step_viol = 0;
            last_l = 3'b000;
            prev_l = comm_tbl[(r + 5) % 6].exp_l;
            hall = comm_tbl[r].hall;
            expect_val(16'd4);
            expect_val(16'd3);
            expect_val(16'd1);
            expect_val({13'd0, comm_tbl[r].exp_l});
            expect_val(16'd0);
            for (int i = 1; i <= 2000; i++) begin
                tick();
                if (i <= 3) begin
                    if (phaseL != prev_l) step_viol++;
                end else if (phaseL == 3'b000) begin
                    if (phaseH == 3'b000) zero_cnt++;
                    else step_viol++;
                    if (first_zero == 0) first_zero = i;
                end else begin
                    if (phaseL != comm_tbl[r].exp_l) step_viol++;
                    if ((phaseH != 3'b000) && (phaseH != comm_tbl[r].exp_h)) step_viol++;
                    if (phaseH == comm_tbl[r].exp_h) hi_cnt++;
                end
                last_l = phaseL;
            end
            check("dead_start", 16'(first_zero));
            check("dead_len", 16'(zero_cnt));
            check("high_seen", {15'd0, hi_cnt > 0});
            check("low_phase", {13'd0, last_l});
            check("step_pattern", 16'(step_viol));
        end
        expect_val(16'b10);
        check("comm_status", {14'd0, connected, fault});

        // 4. Disconnected sensors, then reconnect restarts the ramp.
        hall = 3'b111;
        tick(); tick();
        expect_val(16'd1);
        check("conn_before", {15'd0, connected});
        tick();
        expect_val(16'd0);
        check("conn_drop", {15'd0, connected});
        tick();
        expect_val(16'd0);
        check("disc_gates", {10'd0, phaseH, phaseL});
        count_on(1200, on_cnt);
        expect_val(16'd0);
        check("disc_hold", 16'(on_cnt));
        wait_phase(100);
        hall = 3'b001;
        for (int k = 1; k <= 3; k++) expect_val(16'(k));
        measure_runs(3, 5 * PERIOD);
        expect_val(16'b10);
        check("reconn_status", {14'd0, connected, fault});

        // 5. Non-adjacent jump sets a sticky fault; 000 also faults.
        hall = 3'b110;
        tick(); tick();
        expect_val(16'd0);
        check("fault_before", {15'd0, fault});
        tick();
        expect_val(16'd1);
        check("fault_jump", {15'd0, fault});
        tick();
        expect_val(16'd0);
        check("fault_gates", {10'd0, phaseH, phaseL});
        hall = 3'b001;
        count_on(1100, on_cnt);
        expect_val(16'd0);
        check("fault_hold_gates", 16'(on_cnt));
        expect_val(16'd1);
        check("fault_sticky", {15'd0, fault});
        do_reset(3);
        repeat (10) tick();
        expect_val(16'b10);
        check("fault_cleared", {14'd0, connected, fault});
        hall = 3'b000;
        tick(); tick(); tick();
        expect_val(16'd1);
        check("fault_zero_code", {15'd0, fault});

        // 6. Zero duty, enable drop, re-enable ramp, lower command.
        hall = 3'b001; duty_cycle = 9'h000; en = 1'b1;
        do_reset(3);
        hcnt = 0; lbad = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (phaseH != 3'b000) hcnt++;
            if ((i >= 10) && (phaseL != 3'b010)) lbad++;
        end
        expect_val(16'd0);
        check("zero_duty_high", 16'(hcnt));
        expect_val(16'd0);
        check("zero_duty_low", 16'(lbad));
        duty_cycle = 9'h1FF;
        wait_phase(300);
        expect_val(16'b010);
        check("en_before", {13'd0, phaseL});
        en = 1'b0;
        tick();
        expect_val(16'd0);
        check("en_drop", {10'd0, phaseH, phaseL});
        count_on(600, on_cnt);
        expect_val(16'd0);
        check("en_off_hold", 16'(on_cnt));
        wait_phase(100);
        duty_cycle = 9'h050;
        en = 1'b1;
        for (int k = 1; k <= 3; k++) expect_val(16'(k));
        measure_runs(3, 5 * PERIOD);
        wait_phase(100);
        duty_cycle = 9'h002;
        expect_val(16'd2);
        expect_val(16'd2);
        measure_runs(2, 4 * PERIOD);

        // Final report.
        expect_val(16'd0);
        check("invariants", 16'(inv_viol));
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: actual %0d entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
